// File: rtl/rca_pkg.sv
// Shared definitions for the segmented ripple-carry adder pipeline.
//   DefWidth / DefSegW : default operand width and segment width.
//   rca_stage_t        : per-stage pipeline record at the default configuration
//                        (valid, carry, sub, flags, operand remainder, partial sum).
package rca_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefSegW  = 8;

  typedef struct packed {
    logic                valid;
    logic                carry;  // carry out of the most recently added segment
    logic                sub;
    logic                ovf;    // meaningful only in the last stage
    logic                zero;   // meaningful only in the last stage
    logic [DefWidth-1:0] a_rem;  // operand a, upper segments still to be added
    logic [DefWidth-1:0] b_rem;  // operand b, already inverted for subtract
    logic [DefWidth-1:0] sum;    // completed lower segments of the result
  } rca_stage_t;

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG_W-bit ripple-carry adder slice.
//   a_i, b_i : segment operands
//   cin_i    : carry into bit 0
//   sum_o    : segment sum
//   cout_o   : carry out of the segment MSB
//   cmsb_o   : carry into the segment MSB (used for signed overflow)
module rca_seg #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  always_comb begin : p_ripple
    logic [SEG_W:0] c;
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < int'(SEG_W); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end
    cout_o = c[SEG_W];
    cmsb_o = c[SEG_W-1];
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined segmented ripple-carry adder/subtractor with valid/ready handshake.
// Stage k adds operand segment k using the carry registered by stage k-1; the
// remaining operand segments and finished sum segments travel alongside.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = pipeline advance)
//   a, b, cin, sub      : operands, carry-in (add only), 1 = a - b
//   out_valid/out_ready : output handshake
//   sum, cout, ovf, zero: result, carry out (no-borrow on sub), signed overflow, sum==0
module rca_pipe
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG_W = DefSegW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSEG = (SEG_W == 0) ? 1 : WIDTH / SEG_W;

  if (SEG_W == 0 || SEG_W > WIDTH || (WIDTH % SEG_W) != 0) begin : g_param_check
    $error("rca_pipe: WIDTH must be a non-zero multiple of SEG_W");
  end

  // Same fields as rca_pkg::rca_stage_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             sub;
    logic             ovf;
    logic             zero;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t st_q [NSEG];
  stage_t st_d [NSEG];
  stage_t src  [NSEG];  // record entering each stage's adder

  logic [SEG_W-1:0] seg_sum [NSEG];
  logic [NSEG-1:0]  seg_cout;
  logic [NSEG-1:0]  seg_cmsb;

  assign out_valid = st_q[NSEG-1].valid;
  assign in_ready  = !out_valid | out_ready;

  // Stage 0 sees the raw inputs; subtract is a + ~b + 1 with cin ignored.
  always_comb begin
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].sub   = sub;
    src[0].carry = sub ? 1'b1 : cin;
    src[0].a_rem = a;
    src[0].b_rem = sub ? ~b : b;
    for (int k = 1; k < int'(NSEG); k++) begin
      src[k] = st_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(NSEG); k++) begin : g_seg
    rca_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i    (src[k].a_rem[k*SEG_W +: SEG_W]),
      .b_i    (src[k].b_rem[k*SEG_W +: SEG_W]),
      .cin_i  (src[k].carry),
      .sum_o  (seg_sum[k]),
      .cout_o (seg_cout[k]),
      .cmsb_o (seg_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(NSEG); k++) begin
      st_d[k]                           = src[k];
      st_d[k].sum[k*SEG_W +: SEG_W]     = seg_sum[k];
      st_d[k].carry                     = seg_cout[k];
    end
    // Flags are formed once the whole sum is assembled in the last stage.
    st_d[NSEG-1].ovf  = seg_cmsb[NSEG-1] ^ seg_cout[NSEG-1];
    st_d[NSEG-1].zero = (st_d[NSEG-1].sum == '0);
  end

  // The whole pipe, valid bits included, freezes while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        st_q[k] <= '0;
      end
    end else if (in_ready) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign sum  = st_q[NSEG-1].sum;
  assign cout = st_q[NSEG-1].carry;
  assign ovf  = st_q[NSEG-1].ovf;
  assign zero = st_q[NSEG-1].zero;

  // Operand remainders leaving the last stage and per-segment MSB carries of
  // inner stages have no consumer.
  logic unused_tail;
  assign unused_tail = ^{st_q[NSEG-1].a_rem, st_q[NSEG-1].b_rem, st_q[NSEG-1].sub, seg_cmsb};

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=32, SEG_W=8): directed vectors,
// a randomized back-pressured stream and a mid-flight reset, all checked
// against an arithmetic reference model and a FIFO scoreboard.
module tb_rca_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  rca_pipe #(
    .WIDTH (32),
    .SEG_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  int          n_acc    = 0;
  logic [34:0] exp_q[$];      // {cout, ovf, zero, sum}
  logic [34:0] last_res;
  logic [34:0] held;
  logic        hold_pending = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow judged on signed integer range.
  function automatic logic [34:0] model(input logic [31:0] ia, input logic [31:0] ib,
                                        input logic ic, input logic is);
    logic [32:0] full;
    longint      sres;
    logic        v;
    if (!is) begin
      full = {1'b0, ia} + {1'b0, ib} + {32'd0, ic};
      sres = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
    end else begin
      full = {1'b0, ia} + {1'b0, ~ib} + 33'd1;
      sres = longint'($signed(ia)) - longint'($signed(ib));
    end
    v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {full[32], v, (full[31:0] == 32'd0), full[31:0]};
  endfunction

  // One clock cycle: drive at edge+1, observe at edge+2, then advance.
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ic, input logic is, input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!out_valid | ordy));
    if (hold_pending) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'({cout, ovf, zero, sum}), 64'(held));
    end
    chk("spurious_out", 64'(out_valid && (exp_q.size() == 0)), 64'd0);
    if (out_valid && ordy && exp_q.size() != 0) begin
      last_res = exp_q.pop_front();
      chk("result", 64'({cout, ovf, zero, sum}), 64'(last_res));
      n_pops++;
    end
    hold_pending = out_valid && !ordy;
    held         = {cout, ovf, zero, sum};
    if (iv && in_ready) begin
      exp_q.push_back(model(ia, ib, ic, is));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic is, input logic [34:0] spec_res);
    int acc0;
    int lat;
    int p;
    acc0 = n_acc;
    step(1'b1, ia, ib, ic, is, 1'b1);
    chk({tag, "_accepted"}, 64'(n_acc - acc0), 64'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      p = n_pops;
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      if (n_pops != p) lat = i;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_value"}, 64'(last_res), 64'(spec_res));
  endtask

  initial begin
    int          p0;
    int          acc0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;
    logic        ro;
    logic        iv;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    last_res  = '0;
    held      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors; expected values are {cout, ovf, zero, sum}.
    run_one("carry_seg", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
            {1'b0, 1'b0, 1'b0, 32'h0000_0100});
    run_one("wrap_zero", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
            {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    run_one("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
            {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    run_one("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
    run_one("sub_cin_ign", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
    run_one("add_cin", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0,
            {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    run_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
            {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});

    // Random stream of 16 with random back-pressure.
    p0   = n_pops;
    acc0 = n_acc;
    for (int cyc = 0; cyc < 400 && (n_pops - p0) < 16; cyc++) begin
      iv = ((n_acc - acc0) < 16);
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      step(iv, ra, rb, rc, rs, ro);
    end
    chk("stream_accepted", 64'(n_acc - acc0), 64'd16);
    chk("stream_pops", 64'(n_pops - p0), 64'd16);
    chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

    // Three in flight, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      step(1'b1, ra, rb, 1'b0, 1'b0, 1'b1);
    end
    p0  = n_pops;
    rst = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    rst          = 1'b0;
    hold_pending = 1'b0;
    exp_q.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    chk("midrst_no_stale", 64'(n_pops - p0), 64'd0);
    run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
            {1'b0, 1'b0, 1'b0, 32'h2345_678A});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rca_pipe.md
RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Parameter SEG_W, default 8: segment width; NSEG = WIDTH/SEG_W pipeline stages.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set on a/b/cin/sub is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  sum == 0.

Function
REQ-016 The block SHALL compute {cout,sum} = a + b + cin for sub=0, and a + ~b + 1 for sub=1, modulo 2^WIDTH with cout separate.
REQ-017 Stage k (0..NSEG-1) SHALL add segment k of the operands using the carry registered by stage k-1; stage 0 uses cin (add) or 1 (sub).
REQ-018 Unprocessed upper operand segments and completed lower sum segments SHALL be carried forward in skew registers, so each stage holds exactly one transaction.
REQ-019 Latency SHALL be NSEG cycles from accepted input (in_valid & in_ready) to out_valid, with no stalls; throughput SHALL be one result per cycle.
REQ-020 Pipeline advance condition adv = !out_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-021 When adv=0, all stage registers, including valid bits, SHALL hold.
REQ-022 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-023 sum/cout/ovf/zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 ovf SHALL be computed in the last stage as carry-into-MSB XOR cout.
REQ-025 zero SHALL be computed in the last stage from the full assembled sum.
REQ-026 Simultaneous output pop and input accept SHALL lose no transaction and duplicate none.
REQ-027 WIDTH not divisible by SEG_W, or SEG_W > WIDTH, SHALL be rejected at elaboration.

Reset
REQ-028 While rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0 on the following cycle.
REQ-029 After reset, sum=0, cout=0, ovf=0, zero=0, and in_ready=1.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear on the output.
REQ-031 Data registers other than valid bits and outputs need not be reset.

Structure
REQ-032 The shared package rca_pkg SHALL hold the default WIDTH and SEG_W constants and the stage record typedef (valid, carry, operand remainder, partial sum, sub).
REQ-033 One sub-module, rca_seg (SEG_W-bit combinational ripple adder with cin/cout and carry-into-MSB output), SHALL be instantiated once per stage.

Verification (WIDTH=32, SEG_W=8)
REQ-034 a=0x000000FF, b=0x00000001, cin=0, sub=0 -> after 4 cycles: sum=0x00000100, cout=0, ovf=0, zero=0.
REQ-035 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0, cout=1, zero=1, ovf=0.
REQ-036 a=0x7FFFFFFF, b=0x00000001 add -> sum=0x80000000, ovf=1. Then a=5, b=7 sub -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 Back-to-back stream of 16 random operand sets, out_ready toggling 1-0-1 pseudo-randomly -> in-order results matching the reference model, no loss or duplicate, outputs stable while stalled.
REQ-038 Three transactions in flight, rst=1 for one cycle -> out_valid=0 next cycle; no stale result ever emitted; the next accepted operation returns correctly after 4 cycles.
